// File: rtl/hcsr04_pkg.sv
// hcsr04_pkg: shared types and constants for the HC-SR04 ranger.
//   state_t   : measurement sequencer states
//   AVG_DEPTH : number of good samples averaged when HCSR04_AVG_EN is defined
//   us_div()  : clock cycles per microsecond for a given clock frequency
package hcsr04_pkg;
  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;
  localparam int AVG_DEPTH = 4;
  function automatic int us_div(input int clk_hz);
    return clk_hz / 1_000_000;
  endfunction
endpackage

// File: rtl/hcsr04_us_tick.sv
// hcsr04_us_tick: microsecond prescaler with restart.
//   cclk    : system clock
//   clr_n   : synchronous active-low reset
//   restart : restart the count so the next tick is DIV cycles away
//   tick    : one-cycle strobe every DIV cycles
module hcsr04_us_tick #(
  parameter int DIV = 50
) (
  input  logic cclk,
  input  logic clr_n,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(DIV);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(DIV - 1);
  always_ff @(posedge cclk)
    cnt <= (!clr_n || restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/hcsr04_ranger.sv
// hcsr04_ranger: closed-loop HC-SR04 trigger/echo measurement sequencer.
//   cclk    : system clock          clr_n   : synchronous active-low reset
//   run     : level enable          echo    : raw asynchronous echo pin
//   trig    : sensor trigger pin    echo_us : last echo width in us
//   valid   : echo_us updated       timeout : cycle aborted
//   busy    : sequencer not idle
// Build option HCSR04_AVG_EN: publish the mean of every AVG_DEPTH good samples.
module hcsr04_ranger import hcsr04_pkg::*; #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int TRIG_US    = 10,
  parameter int TIMEOUT_US = 25000,
  parameter int HOLDOFF_US = 60000,
  parameter int CNT_W      = 16
) (
  input  logic             cclk,
  input  logic             clr_n,
  input  logic             run,
  input  logic             echo,
  output logic             trig,
  output logic [CNT_W-1:0] echo_us,
  output logic             valid,
  output logic             timeout,
  output logic             busy
);
  localparam int DIV  = us_div(CLK_HZ);
  localparam int TM1  = HOLDOFF_US > TIMEOUT_US ? HOLDOFF_US : TIMEOUT_US;
  localparam int TMAX = TM1 > TRIG_US ? TM1 : TRIG_US;
  localparam int TW   = $clog2(TMAX + 1);
  state_t state;
  logic [2:0] sync;
  logic [TW-1:0] tmr, lim;
  logic [CNT_W-1:0] meas;
  logic tick, done, leave, rise, fall;
  // sync[1] is the synchronized echo, sync[2] its previous value for edge detect
  assign rise = sync[1] & ~sync[2];
  assign fall = ~sync[1] & sync[2];
  always_comb begin
    lim = state == TRIG ? TW'(TRIG_US - 1) : state == HOLDOFF ? TW'(HOLDOFF_US - 1) : TW'(TIMEOUT_US - 1);
    done = tick && tmr == lim;
    leave = state == IDLE ? run : state == WAIT_RISE ? rise || done : state == MEASURE ? fall || done : done;
    // a fall coinciding with a tick has completed that microsecond
    meas = CNT_W'(tmr) + CNT_W'(tick);
  end
  // every state exit restarts the prescaler, so each state lasts whole us
  hcsr04_us_tick #(.DIV(DIV)) u_tick (.cclk(cclk), .clr_n(clr_n), .restart(leave), .tick(tick));
`ifdef HCSR04_AVG_EN
  localparam int NW = $clog2(AVG_DEPTH);
  logic [CNT_W+1:0] sum, sum_nxt;
  logic [NW-1:0] n;
  assign sum_nxt = sum + (CNT_W + 2)'(meas);
`endif
  always_ff @(posedge cclk) begin
    if (!clr_n) begin
      state <= IDLE;
      sync <= '0;
      tmr <= '0;
      trig <= 1'b0;
      echo_us <= '0;
      valid <= 1'b0;
      timeout <= 1'b0;
      busy <= 1'b0;
`ifdef HCSR04_AVG_EN
      sum <= '0;
      n <= '0;
`endif
    end else begin
      sync <= {sync[1:0], echo};
      tmr <= (leave || state == IDLE) ? '0 : tmr + TW'(tick);
      valid <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: if (run) begin
          state <= TRIG;
          trig <= 1'b1;
          busy <= 1'b1;
        end
        TRIG: if (done) begin
          state <= WAIT_RISE;
          trig <= 1'b0;
        end
        WAIT_RISE: if (rise) state <= MEASURE;
        else if (done) begin
          state <= HOLDOFF;
          timeout <= 1'b1;
`ifdef HCSR04_AVG_EN
          sum <= '0;
          n <= '0;
`endif
        end
        // reaching the limit wins over a simultaneous fall
        MEASURE: if (done) begin
          state <= HOLDOFF;
          timeout <= 1'b1;
`ifdef HCSR04_AVG_EN
          sum <= '0;
          n <= '0;
`endif
        end else if (fall) begin
          state <= HOLDOFF;
`ifdef HCSR04_AVG_EN
          if (n == NW'(AVG_DEPTH - 1)) begin
            valid <= 1'b1;
            echo_us <= CNT_W'(sum_nxt >> NW);
            sum <= '0;
            n <= '0;
          end else begin
            sum <= sum_nxt;
            n <= n + 1'b1;
          end
`else
          valid <= 1'b1;
          echo_us <= meas;
`endif
        end
        HOLDOFF: if (done) begin
          state <= run ? TRIG : IDLE;
          trig <= run;
          busy <= run;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hcsr04_ranger.sv
// tb_hcsr04_ranger: randomized self-checking bench for hcsr04_ranger.
module tb_hcsr04_ranger;
  logic cclk = 1'b0, clr_n = 1'b0, run = 1'b0, echo = 1'b0;
  logic trig, valid, timeout, busy;
  logic [15:0] echo_us;
  logic trig_d = 1'b0;
  int cyc = 0, checks = 0, failures = 0, last_us = 0;
  int tr_q[$], tf_q[$], vt_q[$], vv_q[$], to_q[$];
`ifdef HCSR04_AVG_EN
  int acc = 0, an = 0;
`endif
  hcsr04_ranger #(.CLK_HZ(2_000_000), .TRIG_US(10), .TIMEOUT_US(100), .HOLDOFF_US(50), .CNT_W(16)) dut (
    .cclk(cclk), .clr_n(clr_n), .run(run), .echo(echo), .trig(trig),
    .echo_us(echo_us), .valid(valid), .timeout(timeout), .busy(busy)
  );
  always #5 cclk = ~cclk;
  always @(posedge cclk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  // event log, stamped with the number of the clock edge that produced it
  always @(posedge cclk) begin
    #1;
    if (trig && !trig_d) tr_q.push_back(cyc);
    if (!trig && trig_d) tf_q.push_back(cyc);
    trig_d = trig;
    if (valid) begin
      vt_q.push_back(cyc);
      vv_q.push_back(int'(echo_us));
    end
    if (timeout) to_q.push_back(cyc);
    if (valid || timeout) chk("valid_timeout_excl", int'(valid & timeout), 0);
  end
  task automatic tick_to(input int c);
    while (cyc < c) @(negedge cclk);
  endtask
  task automatic model_good(input int r, output bit v, output int val);
`ifdef HCSR04_AVG_EN
    acc += r;
    an++;
    v = an == 4;
    val = acc >> 2;
    if (v) begin
      acc = 0;
      an = 0;
    end
`else
    v = 1'b1;
    val = r;
`endif
  endtask
  task automatic model_clear();
`ifdef HCSR04_AVG_EN
    acc = 0;
    an = 0;
`endif
  endtask
  // One trigger/echo cycle. With DIV=2: trig lasts 20 cycles, the echo pin
  // edge reaches the state machine 3 edges later, width w cycles reads as
  // w/2 us, and 200 cycles is the timeout in either waiting state.
  task automatic do_cycle(input int exp_rise, input bit has_echo, input int d, input int w,
                          input bit run_next, output int h);
    int r, f;
    bit to_exp, v_exp;
    int val;
    for (int k = 0; k < 500 && tf_q.size() == 0; k++) @(negedge cclk);
    chk("trig_seen", int'(tf_q.size() != 0 && tr_q.size() != 0), 1);
    if (tf_q.size() == 0 || tr_q.size() == 0) begin
      h = cyc;
      return;
    end
    r = tr_q.pop_front();
    f = tf_q.pop_front();
    chk("trig_rise_at", r, exp_rise);
    chk("trig_width", f - r, 20);
    chk("busy_active", int'(busy), 1);
    v_exp = 1'b0;
    to_exp = 1'b0;
    val = 0;
    if (!has_echo) begin
      run = run_next;
      h = f + 200;
      to_exp = 1'b1;
    end else begin
      tick_to(f + d);
      echo = 1'b1;
      for (int i = 0; i < w; i++) begin
        if (i == 5) run = run_next;
        @(negedge cclk);
      end
      echo = 1'b0;
      run = run_next;
      if (w >= 200) begin
        h = f + d + 3 + 200;
        to_exp = 1'b1;
      end else begin
        h = f + d + 3 + w;
        model_good(w / 2, v_exp, val);
      end
    end
    if (to_exp) model_clear();
    tick_to(h + 1);
    chk("valid_count", vt_q.size(), int'(v_exp));
    if (v_exp && vt_q.size() != 0) begin
      chk("valid_at", vt_q[0], h);
      chk("echo_us_val", vv_q[0], val);
      last_us = val;
    end
    chk("timeout_count", to_q.size(), int'(to_exp));
    if (to_exp && to_q.size() != 0) chk("timeout_at", to_q[0], h);
    chk("echo_us_hold", int'(echo_us), last_us);
    chk("busy_holdoff", int'(busy), 1);
    vt_q.delete();
    vv_q.delete();
    to_q.delete();
    if (!run_next) begin
      tick_to(h + 105);
      chk("busy_idle", int'(busy), 0);
      chk("trig_idle", tr_q.size(), 0);
    end
  endtask
  task automatic chk_reset_outputs();
    chk("rst_trig", int'(trig), 0);
    chk("rst_echo_us", int'(echo_us), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_timeout", int'(timeout), 0);
    chk("rst_busy", int'(busy), 0);
  endtask
  initial begin
    int c, h, d_r, w_r;
    bit e_r;
    repeat (3) @(negedge cclk);
    chk_reset_outputs();
    clr_n = 1'b1;
    @(negedge cclk);
    c = cyc;
    run = 1'b1;
    do_cycle(c + 1, 1'b1, 5, 74, 1'b1, h);
    do_cycle(h + 100, 1'b0, 0, 0, 1'b1, h);
    do_cycle(h + 100, 1'b1, 20, 300, 1'b1, h);
    repeat (6) begin
      e_r = $urandom_range(0, 4) != 0;
      d_r = $urandom_range(0, 150);
      w_r = $urandom_range(2, 260);
      do_cycle(h + 100, e_r, d_r, w_r, 1'b1, h);
    end
    do_cycle(h + 100, 1'b1, 8, 90, 1'b0, h);
    c = cyc;
    run = 1'b1;
    tick_to(c + 6);
    chk("trig_mid", int'(trig), 1);
    clr_n = 1'b0;
    run = 1'b0;
    @(negedge cclk);
    chk_reset_outputs();
    clr_n = 1'b1;
    tr_q.delete();
    tf_q.delete();
    vt_q.delete();
    vv_q.delete();
    to_q.delete();
    last_us = 0;
    model_clear();
    @(negedge cclk);
    c = cyc;
    run = 1'b1;
    do_cycle(c + 1, 1'b1, 3, 20, 1'b1, h);
    do_cycle(h + 100, 1'b1, 7, 40, 1'b1, h);
    do_cycle(h + 100, 1'b1, 12, 60, 1'b1, h);
    do_cycle(h + 100, 1'b1, 4, 82, 1'b0, h);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
